// File: rtl/clk_div_enable_gen_if.sv
// Control and status bundle for the programmable clock divider.
// The master side requests run/stop and ratio loads; the slave side reports the divided clock and status.
interface clk_div_enable_gen_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic [WIDTH-1:0] div_in;
    logic             div_load;
    logic             clk_out;
    logic             tick;
    logic             running;
    logic             pending;
    logic             err;

    modport master (
        output enable,
        output div_in,
        output div_load,
        input  clk_out,
        input  tick,
        input  running,
        input  pending,
        input  err
    );

    modport slave (
        input  enable,
        input  div_in,
        input  div_load,
        output clk_out,
        output tick,
        output running,
        output pending,
        output err
    );
endinterface

// File: rtl/clk_div_enable_gen.sv
// Programmable integer clock divider with a one-cycle tick per divided period.
// Ratio changes are deferred to the period boundary so clk_out never produces a runt pulse.
module clk_div_enable_gen #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    clk_div_enable_gen_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH:0]   ONE_WIDE = (WIDTH + 1)'(1);

    state_t           state_reg;
    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cur_div_reg;
    logic [WIDTH-1:0] shadow_reg;
    logic             clk_out_reg;
    logic             tick_reg;
    logic             running_reg;
    logic             pending_reg;
    logic             err_reg;

    logic             load_ok;
    logic             load_bad;
    logic             wrap;
    logic [WIDTH-1:0] cnt_next;
    logic [WIDTH-1:0] div_next;
    logic             high_next;

    // High time is (N+1)/2, evaluated one bit wider so N = 2^WIDTH-1 cannot overflow.
    function automatic logic [WIDTH:0] high_len(input logic [WIDTH-1:0] n);
        logic [WIDTH:0] sum;
        sum = {1'b0, n} + ONE_WIDE;
        return sum >> 1;
    endfunction

    always_comb begin
        load_ok   = bus.div_load && (bus.div_in > ONE);
        load_bad  = bus.div_load && !(bus.div_in > ONE);
        wrap      = (cnt_reg == (cur_div_reg - ONE));
        cnt_next  = wrap ? '0 : (cnt_reg + ONE);
        // Ratio for the period that begins at a wrap; a load on the wrap edge itself wins.
        div_next  = cur_div_reg;
        if (load_ok) begin
            div_next = bus.div_in;
        end else if (pending_reg) begin
            div_next = shadow_reg;
        end
        high_next = ({1'b0, cnt_next} < high_len(cur_div_reg));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            cur_div_reg <= DEF_DIV;
            shadow_reg  <= DEF_DIV;
            clk_out_reg <= 1'b0;
            tick_reg    <= 1'b0;
            running_reg <= 1'b0;
            pending_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            if (load_bad) begin
                err_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (load_ok) begin
                        cur_div_reg <= bus.div_in;
                    end
                    if (bus.enable) begin
                        state_reg   <= RUN;
                        clk_out_reg <= 1'b1;
                        tick_reg    <= 1'b1;
                        running_reg <= 1'b1;
                    end else begin
                        clk_out_reg <= 1'b0;
                        tick_reg    <= 1'b0;
                        running_reg <= 1'b0;
                    end
                end

                RUN, STOP: begin
                    if (wrap) begin
                        cur_div_reg <= div_next;
                        shadow_reg  <= div_next;
                        pending_reg <= 1'b0;
                    end else if (load_ok) begin
                        shadow_reg  <= bus.div_in;
                        pending_reg <= 1'b1;
                    end

                    // Without enable the current period finishes, then the divider parks low.
                    if (!bus.enable && wrap) begin
                        state_reg   <= IDLE;
                        cnt_reg     <= '0;
                        clk_out_reg <= 1'b0;
                        tick_reg    <= 1'b0;
                        running_reg <= 1'b0;
                    end else begin
                        state_reg   <= bus.enable ? RUN : STOP;
                        cnt_reg     <= cnt_next;
                        tick_reg    <= wrap;
                        clk_out_reg <= wrap ? 1'b1 : high_next;
                        running_reg <= 1'b1;
                    end
                end

                default: begin
                    state_reg   <= IDLE;
                    cnt_reg     <= '0;
                    clk_out_reg <= 1'b0;
                    tick_reg    <= 1'b0;
                    running_reg <= 1'b0;
                end
            endcase
        end
    end

    assign bus.clk_out = clk_out_reg;
    assign bus.tick    = tick_reg;
    assign bus.running = running_reg;
    assign bus.pending = pending_reg;
    assign bus.err     = err_reg;

endmodule

// File: tb/tb_clk_div_enable_gen.sv
// Directed plus randomized bench for clk_div_enable_gen, checked every cycle against a period-level model.
module tb_clk_div_enable_gen;

    localparam int WIDTH       = 8;
    localparam int DEFAULT_DIV = 2;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    // Reference model: divider described as "active period of length n, at position pos".
    bit m_active;
    int m_pos;
    int m_n;
    int m_sh;
    bit m_pend;
    bit m_err;

    clk_div_enable_gen_if #(.WIDTH(WIDTH)) bus ();

    clk_div_enable_gen #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_step(input bit rst, input bit en, input bit ld, input int din);
        bit ok;
        bit bad;
        ok  = ld && (din >= 2);
        bad = ld && (din < 2);
        if (rst) begin
            m_active = 1'b0;
            m_pos    = 0;
            m_n      = DEFAULT_DIV;
            m_sh     = DEFAULT_DIV;
            m_pend   = 1'b0;
            m_err    = 1'b0;
        end else begin
            if (bad) m_err = 1'b1;
            if (!m_active) begin
                if (ok) m_n = din;
                if (en) begin
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end else if (m_pos == m_n - 1) begin
                if (ok) m_n = din;
                else if (m_pend) m_n = m_sh;
                m_pend = 1'b0;
                m_pos  = 0;
                if (!en) m_active = 1'b0;
            end else begin
                m_pos = m_pos + 1;
                if (ok) begin
                    m_sh   = din;
                    m_pend = 1'b1;
                end
            end
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s at t=%0t: observed %b expected %b (pos=%0d n=%0d)", tag, $time, obs, exp, m_pos, m_n);
        end
    endtask

    task automatic cycle(input bit rst, input bit en, input bit ld, input int din);
        bit exp_clk;
        @(negedge clk);
        reset        = rst;
        bus.enable   = en;
        bus.div_load = ld;
        bus.div_in   = din[WIDTH-1:0];
        @(posedge clk);
        model_step(rst, en, ld, din);
        #1;
        exp_clk = m_active && (m_pos < (m_n + 1) / 2);
        check_bit("clk_out", bus.clk_out, exp_clk);
        check_bit("tick",    bus.tick,    m_active && (m_pos == 0));
        check_bit("running", bus.running, m_active);
        check_bit("pending", bus.pending, m_pend);
        check_bit("err",     bus.err,     m_err);
        $display("t=%0t rst=%0b en=%0b ld=%0b din=%0d | clk_out=%0b tick=%0b run=%0b pend=%0b err=%0b",
                 $time, rst, en, ld, din, bus.clk_out, bus.tick, bus.running, bus.pending, bus.err);
    endtask

    task automatic run(input int n, input bit en);
        for (int i = 0; i < n; i++) cycle(1'b0, en, 1'b0, 0);
    endtask

    // Advance with enable high until the model sits at the given position of an active period.
    task automatic wait_pos(input int p);
        int budget;
        budget = 600;
        while (!(m_active && m_pos == p) && budget > 0) begin
            cycle(1'b0, 1'b1, 1'b0, 0);
            budget--;
        end
        checks++;
        assert (budget > 0)
        else begin
            errors++;
            $error("FAIL wait_pos timeout: observed pos %0d expected %0d", m_pos, p);
        end
    endtask

    task automatic go_idle();
        int budget;
        budget = 600;
        while (m_active && budget > 0) begin
            cycle(1'b0, 1'b0, 1'b0, 0);
            budget--;
        end
        checks++;
        assert (budget > 0)
        else begin
            errors++;
            $error("FAIL go_idle timeout: observed active %0b expected 0", m_active);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.div_load = 1'b0;
        bus.div_in   = '0;
        m_active = 1'b0; m_pos = 0; m_n = DEFAULT_DIV; m_sh = DEFAULT_DIV; m_pend = 1'b0; m_err = 1'b0;

        // Reset state, then default ratio 2
        cycle(1'b1, 1'b0, 1'b0, 0);
        cycle(1'b1, 1'b1, 1'b0, 0);
        run(2, 1'b0);
        run(8, 1'b1);
        go_idle();

        // N=5 loaded in IDLE, then N=4
        cycle(1'b0, 1'b0, 1'b1, 5);
        run(12, 1'b1);
        go_idle();
        cycle(1'b0, 1'b0, 1'b1, 4);
        run(10, 1'b1);

        // Running at N=4, load N=7 at cnt=1
        wait_pos(1);
        cycle(1'b0, 1'b1, 1'b1, 7);
        run(16, 1'b1);

        // Switch to N=8, then load 6 and 3 within one period
        cycle(1'b0, 1'b1, 1'b1, 8);
        wait_pos(0);
        wait_pos(1);
        cycle(1'b0, 1'b1, 1'b1, 6);
        wait_pos(4);
        cycle(1'b0, 1'b1, 1'b1, 3);
        run(10, 1'b1);

        // Load on the wrap edge itself: N=3 -> 4 takes effect immediately
        wait_pos(2);
        cycle(1'b0, 1'b1, 1'b1, 4);
        run(9, 1'b1);

        // Illegal ratios at N=4: err sticks, period unchanged
        wait_pos(1);
        cycle(1'b0, 1'b1, 1'b1, 1);
        run(9, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 0);
        run(5, 1'b1);

        // Drop enable at cnt=1 of N=4
        wait_pos(1);
        run(6, 1'b0);

        // STOP then re-enable before the wrap
        run(3, 1'b1);
        wait_pos(1);
        cycle(1'b0, 1'b0, 1'b0, 0);
        run(8, 1'b1);

        // Reset at cnt=2 of N=6 with a pending load
        go_idle();
        cycle(1'b0, 1'b0, 1'b1, 6);
        wait_pos(1);
        cycle(1'b0, 1'b1, 1'b1, 9);
        cycle(1'b1, 1'b1, 1'b0, 0);
        run(8, 1'b1);

        // Largest ratio
        go_idle();
        cycle(1'b0, 1'b0, 1'b1, 255);
        run(260, 1'b1);
        go_idle();

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            bit r;
            bit e;
            bit l;
            int d;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) < 8);
            l = ($urandom_range(0, 5) == 0);
            d = ($urandom_range(0, 29) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 10));
            cycle(r, e, l, d);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_div_enable_gen.md
Name: clk_div_enable_gen

Overview:
- Programmable integer clock divider for the clock_source_generation path.
- Produces a divided clock `clk_out` and a one-cycle `tick` strobe, all registered.
- `tick` drives the En input of the downstream D latch stage, so the latch samples once per divided period.
- The divide ratio can change at run time; every change lands on a period boundary, so `clk_out` never shows a runt pulse.

Parameters:
- WIDTH, 8, width of the divide ratio and internal counter.
- DEFAULT_DIV, 2, ratio loaded at reset; must be in the range 2..2^WIDTH-1.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous reset, active-high.
- enable  input  1  run request (level).
- div_in  input  WIDTH  new divide ratio N.
- div_load  input  1  one-cycle strobe that captures div_in.
- clk_out  output  1  divided clock; high (N+1)/2 cycles, low N/2 cycles (integer division).
- tick  output  1  one-cycle pulse on the first cycle of each period; feeds the latch En.
- running  output  1  high in RUN and STOP.
- pending  output  1  a captured ratio is waiting for the next period boundary.
- err  output  1  sticky; set when an illegal ratio is loaded.

Behaviour:
- Everything is synchronous to the clk rising edge. All outputs are registered.
- Reset values: cur_div=DEFAULT_DIV, shadow=DEFAULT_DIV, cnt=0, state=IDLE, clk_out=0, tick=0, running=0, pending=0, err=0.
- Reset takes priority over every other input, including in the middle of a period. After a reset, nothing from a pending load survives.
- States: IDLE, RUN, STOP.
- IDLE:
  - cnt=0, clk_out=0, tick=0.
  - When enable is sampled 1, the next state is RUN with cnt=0, clk_out=1, tick=1 in the first RUN cycle. Latency from enable to tick is 1 clock.
- RUN:
  - cnt counts 0..N-1, then wraps to 0. N is cur_div.
  - clk_out=1 when cnt < (N+1)/2, else 0. It is computed from the next-state cnt, so it stays aligned with cnt.
  - tick=1 exactly when cnt==0.
  - If enable is sampled 0, go to STOP. The current period still completes.
- STOP:
  - Same counting as RUN.
  - At the wrap (cnt==N-1), go to IDLE instead of 0; clk_out goes to 0 and no tick is issued.
  - If enable returns to 1 before the wrap, go back to RUN. The next period starts with no gap.
- Ratio load:
  - div_load with div_in in 2..2^WIDTH-1:
    - In IDLE, cur_div is updated on the next edge; pending stays 0.
    - In RUN or STOP, div_in goes to shadow and pending=1.
    - At the wrap edge (cnt==N-1 -> 0), shadow is copied to cur_div and pending is cleared. The new period uses the new N.
  - A div_load sampled on the wrap edge itself takes effect on that edge, with no extra period of delay.
  - A second load while pending=1 overwrites shadow. Only the last value is applied.
  - div_in 0 or 1: ignored (cur_div, shadow and pending all unchanged) and err=1. err clears only on reset.
- Width: cnt is WIDTH bits. The high-time threshold (N+1)/2 is computed at WIDTH+1 bits so N=2^WIDTH-1 does not overflow.
- N=2: clk_out is high 1 cycle, low 1 cycle, and tick fires every other cycle.

Test Plan:
- Reset, then enable=1 with DEFAULT_DIV=2 -> tick every 2nd cycle starting 1 cycle after enable; clk_out pattern 1,0,1,0; running=1.
- Load N=5 in IDLE, enable -> clk_out high 3 cycles, low 2; tick period 5; N=4 -> high 2, low 2.
- Running at N=4, load N=7 at cnt=1 -> pending=1 until the wrap; the next period is 7 cycles (high 4); no runt pulse; pending=0 after the wrap.
- Load N=6 then N=3 in the same period while running at N=8 -> the next period is 3 cycles; 6 is never applied.
- Load N=1 while running at N=4 -> err=1 and stays set; the period stays 4; pending stays 0.
- Drop enable at cnt=1 of N=4 -> STOP completes cycles 2,3, then IDLE with clk_out=0 and no further tick. Separately, assert reset at cnt=2 of N=6 -> all outputs take reset values the next cycle.
